// File: rtl/nn_buf_pkg.sv
// rtl/nn_buf_pkg.sv - shared types and bit indices for the NN data buffer
//
// Purpose : FSM state type plus the bit positions of the status and
//           err_flags vectors, so the top and its consumers agree on layout.
// Ports   : none (package)

package nn_buf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    LOADED = 2'd2
  } buf_state_t;

  localparam int DATA_W = 64;

  // status bit positions
  localparam int ST_WLOADED   = 0;
  localparam int ST_WBUF_FULL = 1;
  localparam int ST_IN_EMPTY  = 2;
  localparam int ST_IN_FULL   = 3;
  localparam int ST_LOADING   = 4;

  // err_flags bit positions
  localparam int ERR_WOVR     = 0;
  localparam int ERR_IOVR     = 1;
  localparam int ERR_LOADPART = 2;

endpackage

// File: rtl/nn_sync_fifo.sv
// rtl/nn_sync_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose : Holds input words until the compute array takes them. The
//           head word is always visible on pop_data.
// Ports   : clk, n_rst (async active-low)
//           clear            synchronous flush, beats push/pop
//           push, push_data  write side; a push while full is ignored
//           pop, pop_data    read side; pop_data = head word (FWFT)
//           full, empty      derived from the wrap-bit pointers
//           count            occupancy 0..DEPTH

module nn_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra MSB on each pointer distinguishes full from empty when the
  // index bits coincide; DEPTH being a power of two makes wrap free.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/nn_data_buffer.sv
// rtl/nn_data_buffer.sv - weight row buffer and input FIFO feeding the compute array
//
// Purpose : Collects 64-bit words from the bus side. Weight words fill a
//           W_DEPTH-row buffer that is streamed row by row to the array on
//           load_weights; input words queue in a FIFO released to the
//           array only once a full weight set has been delivered.
// Ports   : clk, n_rst (async active-low)
//           push, push_is_weight, push_data   word from the bus side
//           load_weights                      start streaming a full set
//           clear                             synchronous flush of everything
//           w_data, w_row, w_valid, w_ready   weight row stream
//           w_load_done                       pulse after the last row
//           in_data, in_valid, in_ready       input word stream (FWFT)
//           status                            [0] loaded [1] wbuf full [2] in empty
//                                             [3] in full [4] loading
//           err_flags                         sticky [0] weight overrun
//                                             [1] input overrun [2] partial load

module nn_data_buffer
  import nn_buf_pkg::*;
#(
  parameter int W_DEPTH  = 8,
  parameter int IN_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic                       push_is_weight,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       load_weights,
  input  logic                       clear,
  output logic [DATA_W-1:0]          w_data,
  output logic [$clog2(W_DEPTH)-1:0] w_row,
  output logic                       w_valid,
  input  logic                       w_ready,
  output logic                       w_load_done,
  output logic [DATA_W-1:0]          in_data,
  output logic                       in_valid,
  input  logic                       in_ready,
  output logic [7:0]                 status,
  output logic [2:0]                 err_flags
);

  localparam int RW = $clog2(W_DEPTH);
  localparam int CW = $clog2(W_DEPTH + 1);
  localparam int IW = $clog2(IN_DEPTH) + 1;

  buf_state_t        state;
  buf_state_t        state_next;
  logic [DATA_W-1:0] wbuf [W_DEPTH];
  logic [CW-1:0]     wbuf_cnt;
  logic              wbuf_full;
  logic              weights_loaded;

  logic              w_wr;
  logic              load_start;
  logic              hs;
  logic              last_hs;
  logic [2:0]        err_set;

  logic              in_push;
  logic              in_pop;
  logic [DATA_W-1:0] fifo_data;
  logic              in_full;
  logic              in_empty;
  logic [IW-1:0]     in_count;

  assign wbuf_full = (wbuf_cnt == CW'(W_DEPTH));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // All decisions use the registered wbuf_cnt, so a load arriving with the
  // push that completes the set still sees a partial buffer.
  always_comb begin
    state_next = state;
    w_wr       = 1'b0;
    load_start = 1'b0;
    hs         = 1'b0;
    last_hs    = 1'b0;
    err_set    = '0;
    if (!clear) begin
      if (push && push_is_weight) begin
        if (state != LOAD && !wbuf_full) w_wr = 1'b1;
        else                             err_set[ERR_WOVR] = 1'b1;
      end
      if (load_weights && state != LOAD) begin
        if (wbuf_full) load_start = 1'b1;
        else           err_set[ERR_LOADPART] = 1'b1;
      end
      hs      = (state == LOAD) && w_ready;
      last_hs = hs && (w_row == RW'(W_DEPTH - 1));
      // Input overrun is judged on the pre-pop count: a pop in the same
      // cycle does not make room for the incoming word.
      if (in_push && (in_count == IW'(IN_DEPTH))) err_set[ERR_IOVR] = 1'b1;
    end
    case (state)
      IDLE, LOADED: if (load_start) state_next = LOAD;
      LOAD:         if (last_hs)    state_next = LOADED;
      default:                      state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // ------------------------------------------------- counters and flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wbuf_cnt       <= '0;
      w_row          <= '0;
      weights_loaded <= 1'b0;
      w_load_done    <= 1'b0;
      err_flags      <= '0;
    end else if (clear) begin
      wbuf_cnt       <= '0;
      w_row          <= '0;
      weights_loaded <= 1'b0;
      w_load_done    <= 1'b0;
      err_flags      <= '0;
    end else begin
      w_load_done <= last_hs;
      err_flags   <= err_flags | err_set;
      if (w_wr) wbuf_cnt <= wbuf_cnt + 1'b1;
      if (load_start) begin
        weights_loaded <= 1'b0;
        w_row          <= '0;
      end
      if (hs) w_row <= last_hs ? '0 : w_row + 1'b1;
      // The set is consumed: the buffer may refill while the array computes.
      if (last_hs) begin
        wbuf_cnt       <= '0;
        weights_loaded <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) wbuf[wbuf_cnt[RW-1:0]] <= push_data;
  end

  assign w_valid = (state == LOAD);
  assign w_data  = w_valid ? wbuf[w_row] : '0;

  // ---------------------------------------------------------- input FIFO
  assign in_push  = push && !push_is_weight && !clear;
  assign in_valid = !in_empty && weights_loaded;
  assign in_pop   = in_valid && in_ready;
  assign in_data  = in_valid ? fifo_data : '0;

  nn_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .push      (in_push),
    .push_data (push_data),
    .pop       (in_pop),
    .pop_data  (fifo_data),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  // -------------------------------------------------------------- status
  always_comb begin
    status               = '0;
    status[ST_WLOADED]   = weights_loaded;
    status[ST_WBUF_FULL] = wbuf_full;
    status[ST_IN_EMPTY]  = in_empty;
    status[ST_IN_FULL]   = in_full;
    status[ST_LOADING]   = (state == LOAD);
  end

endmodule

// File: tb/tb_nn_data_buffer.sv
// tb/tb_nn_data_buffer.sv - scoreboard bench for nn_data_buffer

module tb_nn_data_buffer;

  localparam int W_DEPTH  = 8;
  localparam int IN_DEPTH = 8;

  logic        clk;
  logic        n_rst;
  logic        push;
  logic        push_is_weight;
  logic [63:0] push_data;
  logic        load_weights;
  logic        clear;
  logic [63:0] w_data;
  logic [2:0]  w_row;
  logic        w_valid;
  logic        w_ready;
  logic        w_load_done;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  status;
  logic [2:0]  err_flags;

  int          checks;
  int          failures;
  logic [63:0] w_q[$];
  logic [63:0] in_q[$];

  nn_data_buffer #(.W_DEPTH(W_DEPTH), .IN_DEPTH(IN_DEPTH)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .push           (push),
    .push_is_weight (push_is_weight),
    .push_data      (push_data),
    .load_weights   (load_weights),
    .clear          (clear),
    .w_data         (w_data),
    .w_row          (w_row),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_load_done    (w_load_done),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .status         (status),
    .err_flags      (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Tasks are entered at a negedge, drive inputs for the coming posedge,
  // and return at a later negedge with their strobes released.
  task automatic push_weights(input int n, input logic [63:0] base, input logic [63:0] step);
    for (int i = 0; i < n; i++) begin
      push = 1'b1; push_is_weight = 1'b1;
      push_data = base + step * 64'(i);
      w_q.push_back(push_data);
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  task automatic pulse_load();
    load_weights = 1'b1;
    @(negedge clk);
    load_weights = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    w_q.delete();
    in_q.delete();
  endtask

  task automatic run_stream(input logic [7:0] pat, input bit inject, output int cycles);
    int          rows;
    int          cyc;
    bit          stalled;
    logic [2:0]  prow;
    logic [63:0] pdata;
    logic [63:0] exp_d;
    rows = 0; cyc = 0; stalled = 0; prow = '0; pdata = '0;
    while (rows < W_DEPTH && cyc < 64) begin
      w_ready = pat[cyc % 8];
      push = inject && (cyc == 1);
      push_is_weight = 1'b1;
      push_data = 64'hdead_beef_0000_0001;
      checks++;
      if (w_valid !== 1'b1 || status[4] !== 1'b1 || in_valid !== 1'b0) begin
        failures++;
        $display("FAIL stream_valid cyc=%0d w_valid=%b loading=%b in_valid=%b required 1 1 0",
                 cyc, w_valid, status[4], in_valid);
      end
      if (stalled) begin
        checks++;
        if (w_row !== prow || w_data !== pdata) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d row=%0d data=%h required row=%0d data=%h",
                   cyc, w_row, w_data, prow, pdata);
        end
      end
      if (w_valid && w_ready) begin
        exp_d = '0;
        if (w_q.size() > 0) exp_d = w_q.pop_front();
        checks++;
        if (w_row !== 3'(rows) || w_data !== exp_d) begin
          failures++;
          $display("FAIL stream_row row=%0d data=%h required row=%0d data=%h",
                   w_row, w_data, rows, exp_d);
        end
        rows++;
      end
      stalled = w_valid && !w_ready;
      prow = w_row;
      pdata = w_data;
      cyc++;
      @(negedge clk);
    end
    push = 1'b0;
    w_ready = 1'b0;
    checks++;
    if (rows != W_DEPTH) begin
      failures++;
      $display("FAIL stream_timeout rows=%0d required %0d", rows, W_DEPTH);
    end
    checks++;
    if (w_load_done !== 1'b1 || w_valid !== 1'b0 || status[0] !== 1'b1 || status[4] !== 1'b0) begin
      failures++;
      $display("FAIL load_done done=%b w_valid=%b loaded=%b loading=%b required 1 0 1 0",
               w_load_done, w_valid, status[0], status[4]);
    end
    @(negedge clk);
    checks++;
    if (w_load_done !== 1'b0) begin
      failures++;
      $display("FAIL done_pulse done=%b required 0", w_load_done);
    end
    cycles = cyc;
  endtask

  task automatic drain_inputs(input int n);
    int          got;
    int          cyc;
    logic [63:0] exp_d;
    got = 0; cyc = 0;
    while (got < n && cyc < 50) begin
      in_ready = 1'b1;
      if (in_valid) begin
        exp_d = '0;
        if (in_q.size() > 0) exp_d = in_q.pop_front();
        checks++;
        if (in_data !== exp_d) begin
          failures++;
          $display("FAIL in_order word=%0d data=%h required %h", got, in_data, exp_d);
        end
        got++;
      end
      cyc++;
      @(negedge clk);
    end
    in_ready = 1'b0;
    checks++;
    if (got != n || in_valid !== 1'b0 || status[2] !== 1'b1) begin
      failures++;
      $display("FAIL in_drain got=%0d in_valid=%b empty=%b required %0d 0 1",
               got, in_valid, status[2], n);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (status !== 8'h04 || err_flags !== 3'b000 || w_valid !== 1'b0 || in_valid !== 1'b0 ||
        w_load_done !== 1'b0 || w_row !== 3'd0 || w_data !== 64'd0 || in_data !== 64'd0) begin
      failures++;
      $display("FAIL reset_outputs status=%h err=%b w_valid=%b in_valid=%b done=%b row=%0d required 04 000 0 0 0 0",
               status, err_flags, w_valid, in_valid, w_load_done, w_row);
    end
    n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (status !== 8'h04 || err_flags !== 3'b000) begin
      failures++;
      $display("FAIL post_reset status=%h err=%b required 04 000", status, err_flags);
    end
  endtask

  task automatic test_weight_load();
    int cyc;
    push_weights(8, 64'h0101, 64'h0101);
    checks++;
    if (status !== 8'h06) begin
      failures++;
      $display("FAIL wbuf_full status=%h required 06", status);
    end
    pulse_load();
    run_stream(8'hFF, 1'b0, cyc);
    checks++;
    if (cyc != 8) begin
      failures++;
      $display("FAIL stream_back_to_back cycles=%0d required 8", cyc);
    end
  endtask

  task automatic test_inputs_gated();
    int cyc;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_is_weight = 1'b0; in_ready = 1'b1;
      push_data = 64'hA000 + 64'(i);
      in_q.push_back(push_data);
      checks++;
      if (in_valid !== 1'b0) begin
        failures++;
        $display("FAIL in_gated_push in_valid=%b required 0", in_valid);
      end
      @(negedge clk);
    end
    push = 1'b0;
    checks++;
    if (in_valid !== 1'b0 || status[2] !== 1'b0 || status[0] !== 1'b0) begin
      failures++;
      $display("FAIL in_gated in_valid=%b empty=%b loaded=%b required 0 0 0",
               in_valid, status[2], status[0]);
    end
    in_ready = 1'b0;
    push_weights(8, 64'h1111_0000, 64'h1);
    pulse_load();
    run_stream(8'hFF, 1'b0, cyc);
    drain_inputs(3);
  endtask

  task automatic test_in_overrun();
    for (int i = 0; i < IN_DEPTH; i++) begin
      push = 1'b1; push_is_weight = 1'b0;
      push_data = 64'hB000 + 64'(i);
      in_q.push_back(push_data);
      @(negedge clk);
    end
    checks++;
    if (status[3] !== 1'b1 || err_flags[1] !== 1'b0 || in_valid !== 1'b1) begin
      failures++;
      $display("FAIL in_full full=%b iovr=%b in_valid=%b required 1 0 1",
               status[3], err_flags[1], in_valid);
    end
    push_data = 64'hBAD0_BAD0;
    in_ready = 1'b1;
    checks++;
    if (in_q.size() == 0 || in_data !== in_q[0]) begin
      failures++;
      $display("FAIL in_pop_on_full data=%h required head word", in_data);
    end
    if (in_q.size() > 0) void'(in_q.pop_front());
    @(negedge clk);
    push = 1'b0;
    in_ready = 1'b0;
    checks++;
    if (err_flags[1] !== 1'b1 || status[3] !== 1'b0) begin
      failures++;
      $display("FAIL in_overrun iovr=%b full=%b required 1 0", err_flags[1], status[3]);
    end
    drain_inputs(7);
  endtask

  task automatic test_load_partial();
    int cyc;
    do_clear();
    push_weights(5, 64'h5000, 64'h1);
    pulse_load();
    checks++;
    if (w_valid !== 1'b0 || err_flags !== 3'b100 || status[1] !== 1'b0) begin
      failures++;
      $display("FAIL load_partial w_valid=%b err=%b full=%b required 0 100 0",
               w_valid, err_flags, status[1]);
    end
    push_weights(3, 64'h5005, 64'h1);
    pulse_load();
    run_stream(8'hFF, 1'b0, cyc);
  endtask

  task automatic test_push_with_load();
    int cyc;
    do_clear();
    checks++;
    if (err_flags !== 3'b000) begin
      failures++;
      $display("FAIL clear_err err=%b required 000", err_flags);
    end
    push_weights(7, 64'h7000, 64'h10);
    push = 1'b1; push_is_weight = 1'b1; load_weights = 1'b1;
    push_data = 64'h7070;
    w_q.push_back(push_data);
    @(negedge clk);
    push = 1'b0; load_weights = 1'b0;
    checks++;
    if (w_valid !== 1'b0 || err_flags[2] !== 1'b1 || status[1] !== 1'b1) begin
      failures++;
      $display("FAIL push_with_load w_valid=%b loadpart=%b full=%b required 0 1 1",
               w_valid, err_flags[2], status[1]);
    end
    pulse_load();
    run_stream(8'hFF, 1'b0, cyc);
  endtask

  task automatic test_stall();
    int cyc;
    checks++;
    if (err_flags[0] !== 1'b0) begin
      failures++;
      $display("FAIL wovr_pre wovr=%b required 0", err_flags[0]);
    end
    push_weights(8, 64'hC0DE_0000_0000_0000, 64'h0001_0000_0000_0001);
    pulse_load();
    run_stream(8'b1001_1001, 1'b1, cyc);
    checks++;
    if (err_flags[0] !== 1'b1 || status[1] !== 1'b0 || cyc != 16) begin
      failures++;
      $display("FAIL stall_wovr wovr=%b full=%b cycles=%0d required 1 0 16",
               err_flags[0], status[1], cyc);
    end
  endtask

  task automatic test_clear_mid_load();
    logic [63:0] exp_d;
    pulse_load();
    checks++;
    if (err_flags[2] !== 1'b1) begin
      failures++;
      $display("FAIL preload_err loadpart=%b required 1", err_flags[2]);
    end
    push_weights(8, 64'hD000, 64'h1);
    pulse_load();
    for (int i = 0; i < 3; i++) begin
      w_ready = 1'b1;
      exp_d = '0;
      if (w_q.size() > 0) exp_d = w_q.pop_front();
      checks++;
      if (w_valid !== 1'b1 || w_data !== exp_d) begin
        failures++;
        $display("FAIL clr_stream w_valid=%b data=%h required 1 %h", w_valid, w_data, exp_d);
      end
      @(negedge clk);
    end
    checks++;
    if (w_row !== 3'd3) begin
      failures++;
      $display("FAIL clr_row row=%0d required 3", w_row);
    end
    clear = 1'b1; push = 1'b1; push_is_weight = 1'b0; push_data = 64'hEEEE;
    @(negedge clk);
    clear = 1'b0; push = 1'b0; w_ready = 1'b0;
    w_q.delete();
    checks++;
    if (w_valid !== 1'b0 || w_load_done !== 1'b0 || status !== 8'h04 ||
        err_flags !== 3'b000 || w_row !== 3'd0) begin
      failures++;
      $display("FAIL clear_mid_load w_valid=%b done=%b status=%h err=%b row=%0d required 0 0 04 000 0",
               w_valid, w_load_done, status, err_flags, w_row);
    end
    @(negedge clk);
    checks++;
    if (w_load_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_done done=%b required 0", w_load_done);
    end
  endtask

  task automatic test_async_reset();
    push_weights(8, 64'hF000, 64'h1);
    pulse_load();
    w_ready = 1'b1;
    repeat (2) @(negedge clk);
    w_ready = 1'b0;
    checks++;
    if (w_row !== 3'd2 || w_valid !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre row=%0d w_valid=%b required 2 1", w_row, w_valid);
    end
    #2 n_rst = 1'b0;
    #1;
    checks++;
    if (w_valid !== 1'b0 || w_row !== 3'd0 || status !== 8'h04 || err_flags !== 3'b000) begin
      failures++;
      $display("FAIL async_reset w_valid=%b row=%0d status=%h err=%b required 0 0 04 000",
               w_valid, w_row, status, err_flags);
    end
    @(negedge clk);
    n_rst = 1'b1;
    w_q.delete();
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    n_rst = 1'b0; push = 1'b0; push_is_weight = 1'b0; push_data = '0;
    load_weights = 1'b0; clear = 1'b0; w_ready = 1'b0; in_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_weight_load();
    test_inputs_gated();
    test_in_overrun();
    test_load_partial();
    test_push_with_load();
    test_stall();
    test_clear_mid_load();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
